// File: rtl/result_pack_wb_pkg.sv
// Shared types and sizing for the result pack/write-back slice.
// Optional build macro: RESULT_PACK_ZERO_FILL_EN (zero-filled full-word writes).
`ifndef ADDR_SIZE
`define ADDR_SIZE 12
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

package result_pack_wb_pkg;

  localparam int unsigned ADDR_W     = `ADDR_SIZE;
  localparam int unsigned DATA_W     = `DATA_WIDTH;
  localparam int unsigned LANES      = 4;
  localparam int unsigned LANE_W     = $clog2(LANES);
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned WADDR_W    = ADDR_W - LANE_W;
  localparam int unsigned WORD_W     = DATA_W * LANES;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  typedef struct packed {
    logic [WADDR_W-1:0] waddr;
    logic [WORD_W-1:0]  data;
    logic [LANES-1:0]   be;
  } pack_t;

  function automatic logic [LANES-1:0] lane_onehot(input logic [LANE_W-1:0] lane);
    lane_onehot = LANES'(1) << lane;
  endfunction

endpackage

// File: rtl/result_wb_fifo.sv
// Packed-word FIFO; shift-register storage so the head is always entry 0.
// A push at full without a simultaneous pop is dropped and flagged sticky.
module result_wb_fifo
  import result_pack_wb_pkg::*;
(
  input  logic  clk,
  input  logic  rstn,
  input  logic  i_push,
  input  pack_t i_din,
  input  logic  i_pop,
  output pack_t o_head,
  output logic  o_nonempty,
  output logic  o_full,
  output logic  o_overflow
);

  pack_t            r_mem [FIFO_DEPTH];
  logic [CNT_W-1:0] r_count;
  logic             r_nonempty;
  logic             r_overflow;

  logic             w_pop;
  logic             w_full;
  logic             w_push_ok;
  logic [CNT_W-1:0] w_wr_idx;
  logic [CNT_W-1:0] w_count_nxt;

  assign w_full      = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_pop       = i_pop && r_nonempty;
  assign w_push_ok   = i_push && (!w_full || w_pop);
  assign w_wr_idx    = r_count - CNT_W'(w_pop);
  assign w_count_nxt = r_count + CNT_W'(w_push_ok) - CNT_W'(w_pop);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_count    <= '0;
      r_nonempty <= 1'b0;
      r_overflow <= 1'b0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
    end else begin
      r_count    <= w_count_nxt;
      r_nonempty <= (w_count_nxt != '0);
      if (i_push && !w_push_ok) r_overflow <= 1'b1;
      // Pop shifts toward the head; a push lands just past the surviving entries.
      for (int unsigned i = 0; i < FIFO_DEPTH - 1; i++) begin
        if (w_push_ok && (w_wr_idx == CNT_W'(i))) r_mem[i] <= i_din;
        else if (w_pop)                            r_mem[i] <= r_mem[i+1];
      end
      if (w_push_ok && (w_wr_idx == CNT_W'(FIFO_DEPTH - 1))) r_mem[FIFO_DEPTH-1] <= i_din;
    end
  end

  assign o_head     = r_mem[0];
  assign o_nonempty = r_nonempty;
  assign o_full     = w_full;
  assign o_overflow = r_overflow;

endmodule

// File: rtl/result_pack_wb.sv
// Packs int8 results into LANES-wide words with byte enables and writes them out via req/gnt.
// Optional build macro: RESULT_PACK_ZERO_FILL_EN (all lanes enabled, missing lanes zero).
module result_pack_wb
  import result_pack_wb_pkg::*;
(
  input  logic               clk,
  input  logic               rstn,
  input  logic [ADDR_W-1:0]  in_addr,
  input  logic [DATA_W-1:0]  in_data,
  input  logic               in_vld,
  input  logic               in_done,
  output logic [WADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0]  mem_wdata,
  output logic [LANES-1:0]   mem_be,
  output logic               mem_req,
  input  logic               mem_gnt,
  output logic               busy,
  output logic               done,
  output logic               overflow
);

  state_t             r_state;
  logic [WADDR_W-1:0] r_pk_waddr;
  logic [WORD_W-1:0]  r_pk_data;
  logic [LANES-1:0]   r_pk_be;
  logic               r_pk_vld;
  logic               r_done;
  logic               r_in_done_q;

  logic [WADDR_W-1:0] w_in_waddr;
  logic [LANE_W-1:0]  w_lane;
  logic [LANES-1:0]   w_lane_oh;
  logic               w_accept;
  logic               w_pk_full;
  logic               w_new_word;
  logic               w_load;
  logic               w_push;
  logic               w_push_en;
  logic               w_pop;
  logic [WORD_W-1:0]  w_ins_data;
  pack_t              w_push_word;
  pack_t              w_head;
  logic               w_fifo_nonempty;
  logic               w_fifo_full;
  logic               w_fifo_ovf;

  assign w_in_waddr = in_addr[ADDR_W-1:LANE_W];
  assign w_lane     = in_addr[LANE_W-1:0];
  assign w_lane_oh  = lane_onehot(w_lane);
  assign w_accept   = in_vld && ((r_state == IDLE) || (r_state == RUN));
  assign w_pk_full  = r_pk_vld && (&r_pk_be);
  assign w_new_word = w_pk_full || (r_pk_vld && (w_in_waddr != r_pk_waddr));
  assign w_load     = w_accept && (!r_pk_vld || w_new_word);
  assign w_push     = r_pk_vld && (w_pk_full || (w_accept && w_new_word) || (r_state == FLUSH));
  assign w_pop      = mem_req && mem_gnt;
  // While flushing the pack is held and retried rather than dropped at full.
  assign w_push_en  = w_push && ((r_state != FLUSH) || !w_fifo_full || w_pop);

  always_comb begin
`ifdef RESULT_PACK_ZERO_FILL_EN
    w_ins_data = w_load ? '0 : r_pk_data;
`else
    w_ins_data = r_pk_data;
`endif
    for (int unsigned k = 0; k < LANES; k++) begin
      if (w_lane == LANE_W'(k)) w_ins_data[k*DATA_W +: DATA_W] = in_data;
    end
  end

  always_comb begin
    w_push_word       = '0;
    w_push_word.waddr = r_pk_waddr;
    w_push_word.data  = r_pk_data;
`ifdef RESULT_PACK_ZERO_FILL_EN
    w_push_word.be    = '1;
`else
    w_push_word.be    = r_pk_be;
`endif
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pk_vld   <= 1'b0;
      r_pk_waddr <= '0;
      r_pk_data  <= '0;
      r_pk_be    <= '0;
    end else if (w_load) begin
      r_pk_vld   <= 1'b1;
      r_pk_waddr <= w_in_waddr;
      r_pk_be    <= w_lane_oh;
      r_pk_data  <= w_ins_data;
    end else if (w_accept) begin
      r_pk_be    <= r_pk_be | w_lane_oh;
      r_pk_data  <= w_ins_data;
    end else if (w_push_en) begin
      r_pk_vld   <= 1'b0;
      r_pk_be    <= '0;
    end
  end

  // Run control; IDLE only re-enters DONE on a rising edge of in_done.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= IDLE;
      r_done      <= 1'b0;
      r_in_done_q <= 1'b0;
    end else begin
      r_in_done_q <= in_done;
      r_done      <= 1'b0;
      case (r_state)
        IDLE: begin
          if (in_vld) begin
            r_state <= RUN;
          end else if (in_done && !r_in_done_q && !r_pk_vld && !mem_req) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end
        end
        RUN: begin
          if (in_done) r_state <= FLUSH;
        end
        FLUSH: begin
          if (!r_pk_vld && !mem_req) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  result_wb_fifo u_fifo (
    .clk        (clk),
    .rstn       (rstn),
    .i_push     (w_push_en),
    .i_din      (w_push_word),
    .i_pop      (w_pop),
    .o_head     (w_head),
    .o_nonempty (w_fifo_nonempty),
    .o_full     (w_fifo_full),
    .o_overflow (w_fifo_ovf)
  );

  assign mem_req   = w_fifo_nonempty;
  assign mem_addr  = w_head.waddr;
  assign mem_wdata = w_head.data;
  assign mem_be    = w_head.be;
  assign busy      = r_pk_vld || w_fifo_nonempty || (r_state == FLUSH);
  assign done      = r_done;
  assign overflow  = w_fifo_ovf;

endmodule

// File: tb/tb_result_pack_wb.sv
// Directed bench for result_pack_wb; expectations adapt to RESULT_PACK_ZERO_FILL_EN.
module tb_result_pack_wb;
  import result_pack_wb_pkg::*;

  logic               clk;
  logic               rstn;
  logic [ADDR_W-1:0]  in_addr;
  logic [DATA_W-1:0]  in_data;
  logic               in_vld;
  logic               in_done;
  logic [WADDR_W-1:0] mem_addr;
  logic [WORD_W-1:0]  mem_wdata;
  logic [LANES-1:0]   mem_be;
  logic               mem_req;
  logic               mem_gnt;
  logic               busy;
  logic               done;
  logic               overflow;

  logic  gnt_lvl;
  logic  gnt_tog_en;
  logic  gnt_tog;
  int    n_checks;
  int    n_errors;
  pack_t got[$];
  logic        stall_q;
  logic [63:0] held;

  assign mem_gnt = gnt_tog_en ? gnt_tog : gnt_lvl;

  result_pack_wb dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_addr   (in_addr),
    .in_data   (in_data),
    .in_vld    (in_vld),
    .in_done   (in_done),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_req   (mem_req),
    .mem_gnt   (mem_gnt),
    .busy      (busy),
    .done      (done),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) gnt_tog <= gnt_tog_en ? ~gnt_tog : 1'b1;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Log every completed transfer and require the head to hold while stalled.
  always @(posedge clk) begin
    if (rstn && stall_q) check("stall_hold", 64'({mem_addr, mem_wdata, mem_be}), held);
    stall_q = rstn && mem_req && !mem_gnt;
    held    = 64'({mem_addr, mem_wdata, mem_be});
    if (rstn && mem_req && mem_gnt) got.push_back(pack_t'{waddr: mem_addr, data: mem_wdata, be: mem_be});
  end

  task automatic send(input int a, input int d);
    in_addr = ADDR_W'(a);
    in_data = DATA_W'(d);
    in_vld  = 1'b1;
    @(negedge clk);
    in_vld  = 1'b0;
  endtask

  task automatic do_reset();
    rstn = 1'b0; in_vld = 1'b0; in_done = 1'b0; in_addr = '0; in_data = '0;
    gnt_lvl = 1'b1; gnt_tog_en = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    got.delete();
  endtask

  task automatic finish_run(input string tag);
    bit seen;
    seen = 1'b0;
    in_done = 1'b1;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check({tag, "_done_seen"}, 64'(seen), 64'(1));
    @(negedge clk);
    check({tag, "_done_pulse"}, 64'(done), 64'(0));
    in_done = 1'b0;
    @(negedge clk);
  endtask

  // Expected transfer idx; data given with zeros in disabled lanes, compared on enabled lanes.
  task automatic check_xfer(input string tag, input int idx, input int a,
                            input logic [WORD_W-1:0] d, input logic [LANES-1:0] be);
    pack_t            g;
    logic [WORD_W-1:0] m;
    logic [LANES-1:0]  be_exp;
`ifdef RESULT_PACK_ZERO_FILL_EN
    be_exp = '1;
`else
    be_exp = be;
`endif
    if (idx >= got.size()) begin
      check({tag, "_present"}, 64'(got.size()), 64'(idx + 1));
      return;
    end
    g = got[idx];
    m = '0;
    for (int k = 0; k < LANES; k++) if (be_exp[k]) m[k*DATA_W +: DATA_W] = '1;
    check({tag, "_addr"}, 64'(g.waddr), 64'(a));
    check({tag, "_be"}, 64'(g.be), 64'(be_exp));
    check({tag, "_data"}, 64'(g.data & m), 64'(d & m));
  endtask

  function automatic logic [WORD_W-1:0] seq_word(input int w, input int off);
    logic [WORD_W-1:0] r;
    for (int k = 0; k < LANES; k++) r[k*DATA_W +: DATA_W] = DATA_W'(LANES * w + k + off);
    return r;
  endfunction

  initial begin
    n_checks = 0; n_errors = 0; stall_q = 1'b0; held = '0;
    gnt_lvl = 1'b1; gnt_tog_en = 1'b0;
    rstn = 1'b0; in_vld = 1'b0; in_done = 1'b0; in_addr = '0; in_data = '0;
    #12;
    check("rst_req", 64'(mem_req), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_ovf", 64'(overflow), 64'(0));
    do_reset();

    // Idle done: pulse the cycle after the in_done edge, no re-entry while level stays high
    in_done = 1'b1;
    @(negedge clk); check("idle_done", 64'(done), 64'(1));
    @(negedge clk); check("idle_done_end", 64'(done), 64'(0));
    @(negedge clk); check("idle_no_reenter", 64'(done), 64'(0));
    in_done = 1'b0;
    @(negedge clk);

    // Full word latency
    got.delete();
    send(0, 1); send(1, 2); send(2, 3); send(3, 4);
    check("t1_req_n1", 64'(mem_req), 64'(0));
    @(negedge clk);
    check("t1_req_n2", 64'(mem_req), 64'(1));
    check("t1_addr", 64'(mem_addr), 64'(0));
    check("t1_wdata", 64'(mem_wdata), 64'h04030201);
    check("t1_be", 64'(mem_be), 64'hf);
    finish_run("t1");
    check("t1_count", 64'(got.size()), 64'(1));

    // Two partial words in different memory words
    got.delete();
    send(5, 8'h11); send(20, 8'h22);
    check("t2_busy", 64'(busy), 64'(1));
    finish_run("t2");
    check("t2_count", 64'(got.size()), 64'(2));
    check_xfer("t2_w1", 0, 1, 32'h0000_1100, 4'b0010);
    check_xfer("t2_w5", 1, 5, 32'h0000_0022, 4'b0001);
    check("t2_idle_busy", 64'(busy), 64'(0));

    // Full word restarts pack for the same word; repeated lane overwrites
    got.delete();
    send(8, 1); send(9, 2); send(10, 3); send(11, 4); send(10, 8'h77); send(10, 8'h88);
    finish_run("t7");
    check("t7_count", 64'(got.size()), 64'(2));
    check_xfer("t7_full", 0, 2, 32'h04030201, 4'b1111);
    check_xfer("t7_part", 1, 2, 32'h0088_0000, 4'b0100);

    // Overflow: five full words with no grant, only the first four survive
    do_reset();
    gnt_lvl = 1'b0;
    for (int i = 0; i < 20; i++) send(i, i + 1);
    check("t3_ovf_before", 64'(overflow), 64'(0));
    @(negedge clk);
    check("t3_ovf_after", 64'(overflow), 64'(1));
    gnt_lvl = 1'b1;
    finish_run("t3");
    check("t3_count", 64'(got.size()), 64'(4));
    for (int w = 0; w < 4; w++) check_xfer($sformatf("t3_w%0d", w), w, w, seq_word(w, 1), 4'b1111);
    check("t3_ovf_sticky", 64'(overflow), 64'(1));

    // Grant toggling every cycle
    do_reset();
    gnt_tog_en = 1'b1;
    for (int i = 0; i < 12; i++) send(i, i + 7);
    send(13, 8'h5a);
    finish_run("t4");
    gnt_tog_en = 1'b0;
    check("t4_count", 64'(got.size()), 64'(4));
    for (int w = 0; w < 3; w++) check_xfer($sformatf("t4_w%0d", w), w, w, seq_word(w, 7), 4'b1111);
    check_xfer("t4_w3", 3, 3, 32'h0000_5a00, 4'b0010);

    // Asynchronous reset with three words queued and overflow set
    do_reset();
    gnt_lvl = 1'b0;
    for (int i = 0; i < 20; i++) send(i, i + 1);
    @(negedge clk);
    gnt_lvl = 1'b1;
    @(negedge clk);
    gnt_lvl = 1'b0;
    check("t5_req_pre", 64'(mem_req), 64'(1));
    check("t5_ovf_pre", 64'(overflow), 64'(1));
    #2 rstn = 1'b0;
    #1;
    check("t5_req_rst", 64'(mem_req), 64'(0));
    check("t5_busy_rst", 64'(busy), 64'(0));
    check("t5_ovf_rst", 64'(overflow), 64'(0));
    do_reset();

    // Clean single-element run after reset
    send(6, 8'hff);
    finish_run("t6");
    check("t6_count", 64'(got.size()), 64'(1));
    check_xfer("t6_w1", 0, 1, 32'h00ff_0000, 4'b0100);
    check("t6_ovf", 64'(overflow), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
